// File: rtl/paralelo_serial_phy_tx.sv
// paralelo_serial_phy_tx: transmit-side byte-to-bit serializer.
// Bytes enter through a valid/ready handshake into a small FIFO and leave
// MSB-first, one bit per clk_32f cycle. After reset a run of COM alignment
// bytes is sent before data/fill bytes.
// Build option: define PHY_TX_IDLE_COM_EN to send COM instead of IDLE as
// the fill byte when the FIFO is empty in RUN.
module paralelo_serial_phy_tx #(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         ALIGN_COUNT = 4,
  parameter logic [7:0] COM         = 8'hBC,
  parameter logic [7:0] IDLE        = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       data_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ALIGN_COUNT + 1) + 1;
  localparam logic [CW-1:0] ALIGN_LAST = CW'(ALIGN_COUNT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

`ifdef PHY_TX_IDLE_COM_EN
  // Empty FIFO keeps refreshing the receiver's alignment.
  localparam logic [7:0] FILL_BYTE = COM;
`else
  localparam logic [7:0] FILL_BYTE = IDLE;
`endif

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] com_cnt_q, com_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic          data_out_q, data_out_d;
  logic          byte_strobe_q, byte_strobe_d;
  logic          active_q, active_d;
  logic          ready_q, ready_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];

  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;
  logic          run_sel_s;
  logic [7:0]    byte_sel_s;

  // Pointer compare gives empty; a push needs the registered ready.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign push_s       = valid_in & ready_q;

  // Sequencer: byte selection on boundaries, bit shifting otherwise.
  always_comb begin
    state_d       = state_q;
    com_cnt_d     = com_cnt_q;
    bit_cnt_d     = bit_cnt_q + 3'd1;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    byte_strobe_d = 1'b0;
    active_d      = active_q;
    pop_s         = 1'b0;
    run_sel_s     = 1'b0;
    byte_sel_s    = COM;
    if (bit_cnt_q == 3'd0) begin
      case (state_q)
        ST_INIT: begin
          if (com_cnt_q == ALIGN_LAST) begin
            // Alignment done: this very boundary already selects as RUN.
            state_d   = ST_RUN;
            run_sel_s = 1'b1;
          end else begin
            com_cnt_d = com_cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          run_sel_s = 1'b1;
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
      if (run_sel_s) begin
        active_d = 1'b1;
        if (!fifo_empty_s) begin
          byte_sel_s = mem_q[rd_ptr_q[AW-1:0]];
          pop_s      = 1'b1;
        end else begin
          byte_sel_s = FILL_BYTE;
        end
      end else begin
        byte_sel_s = COM;
      end
      data_out_d    = byte_sel_s[7];
      byte_strobe_d = 1'b1;
      shift_d       = byte_sel_s[6:0];
    end else begin
      data_out_d    = shift_q[6];
      byte_strobe_d = 1'b0;
      shift_d       = {shift_q[5:0], 1'b0};
    end
  end

  // FIFO next state: pop reads pre-edge contents, so no same-edge bypass.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ready_d  = ready_q;
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_in;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Ready tracks "not full" of the post-edge pointers.
    ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  // State register with synchronous reset; reset aborts any partial byte.
  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      state_q       <= ST_INIT;
      bit_cnt_q     <= 3'd0;
      com_cnt_q     <= '0;
      shift_q       <= 7'd0;
      data_out_q    <= 1'b0;
      byte_strobe_q <= 1'b0;
      active_q      <= 1'b0;
      ready_q       <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      com_cnt_q     <= com_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      byte_strobe_q <= byte_strobe_d;
      active_q      <= active_d;
      ready_q       <= ready_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_q         <= mem_d;
    end
  end

  assign ready       = ready_q;
  assign data_out    = data_out_q;
  assign byte_strobe = byte_strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_paralelo_serial_phy_tx.sv
// Testbench for paralelo_serial_phy_tx: a constant vector table for the
// alignment/single-byte case, then hand sequences and random traffic
// checked against a byte-queue reference model.
module tb_paralelo_serial_phy_tx;

  localparam int         DEPTH = 4;
  localparam int         AC    = 4;
  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [7:0] IDLE  = 8'h7C;
`ifdef PHY_TX_IDLE_COM_EN
  localparam logic [7:0] FILL  = COM;
`else
  localparam logic [7:0] FILL  = IDLE;
`endif

  logic       clk_32f        = 1'b0;
  logic       default_values = 1'b1;
  logic [7:0] data_in        = 8'h00;
  logic       valid_in       = 1'b0;
  logic       ready;
  logic       data_out;
  logic       byte_strobe;
  logic       active;

  paralelo_serial_phy_tx #(
    .FIFO_DEPTH (DEPTH),
    .ALIGN_COUNT(AC),
    .COM        (COM),
    .IDLE       (IDLE)
  ) dut (
    .clk_32f       (clk_32f),
    .default_values(default_values),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .ready         (ready),
    .data_out      (data_out),
    .byte_strobe   (byte_strobe),
    .active        (active)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       valid;
    logic [7:0] din;
    logic       exp_dout;
    logic       exp_strobe;
    logic       exp_active;
    logic       exp_ready;
  } vec_t;

  vec_t vt [48];

  // Reference model: edge number since release, byte queue, current byte.
  logic [7:0] m_q [$];
  int         m_edge  = 0;
  logic       m_ready = 1'b0;
  logic [7:0] m_cur   = 8'h00;
  logic       e_dout   = 1'b0;
  logic       e_strobe = 1'b0;
  logic       e_active = 1'b0;
  logic       e_ready  = 1'b0;

  task automatic check4(input string name, input int ed, input logic wd,
                        input logic ws, input logic wa, input logic wr);
    n_checks++;
    if (data_out !== wd || byte_strobe !== ws || active !== wa || ready !== wr) begin
      n_errors++;
      $display("FAIL %s edge=%0d got dout/strobe/active/ready=%b%b%b%b want %b%b%b%b",
               name, ed, data_out, byte_strobe, active, ready, wd, ws, wa, wr);
    end
  endtask

  // One clock edge with the given inputs, model update, then compare.
  task automatic cycle(input string name, input logic rst, input logic v,
                       input logic [7:0] d);
    int   pos;
    int   bidx;
    logic push;
    default_values = rst;
    valid_in       = v;
    data_in        = d;
    @(posedge clk_32f);
    if (rst) begin
      m_q.delete();
      m_edge   = 0;
      m_ready  = 1'b0;
      m_cur    = 8'h00;
      e_dout   = 1'b0;
      e_strobe = 1'b0;
      e_active = 1'b0;
      e_ready  = 1'b0;
    end else begin
      m_edge++;
      pos  = (m_edge - 1) % 8;
      bidx = (m_edge - 1) / 8;
      push = v && m_ready;
      if (pos == 0) begin
        if (bidx < AC) m_cur = COM;
        else if (m_q.size() != 0) m_cur = m_q.pop_front();
        else m_cur = FILL;
      end
      if (push) m_q.push_back(d);
      m_ready  = (m_q.size() < DEPTH);
      e_dout   = m_cur[7 - pos];
      e_strobe = (pos == 0);
      e_active = (bidx >= AC);
      e_ready  = m_ready;
    end
    #1;
    check4(name, m_edge, e_dout, e_strobe, e_active, e_ready);
  endtask

  initial begin
    logic [7:0] sel;
    logic [7:0] nxt;
    logic [7:0] rd;
    logic       acc;
    int         guard;

    // Vector table: COM x4, one fill byte, then 8'hA5 pushed at edge 34.
    for (int e = 1; e <= 48; e++) begin
      if (e <= 32) sel = COM;
      else if (e <= 40) sel = FILL;
      else sel = 8'hA5;
      vt[e-1].valid      = (e == 34);
      vt[e-1].din        = (e == 34) ? 8'hA5 : 8'h00;
      vt[e-1].exp_dout   = sel[7 - ((e - 1) % 8)];
      vt[e-1].exp_strobe = ((e - 1) % 8 == 0);
      vt[e-1].exp_active = (e >= 33);
      vt[e-1].exp_ready  = 1'b1;
    end

    default_values = 1'b1;
    valid_in       = 1'b0;
    repeat (2) begin
      @(posedge clk_32f);
      #1;
      check4("reset_state", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    default_values = 1'b0;
    for (int i = 0; i < 48; i++) begin
      valid_in = vt[i].valid;
      data_in  = vt[i].din;
      @(posedge clk_32f);
      #1;
      check4("align_tbl", i + 1, vt[i].exp_dout, vt[i].exp_strobe,
             vt[i].exp_active, vt[i].exp_ready);
    end
    valid_in = 1'b0;

    // Backpressure: 01..06 presented from edge 33, retried while not ready.
    cycle("bp_rst", 1'b1, 1'b0, 8'h00);
    cycle("bp_rst", 1'b1, 1'b0, 8'h00);
    repeat (32) cycle("bp_align", 1'b0, 1'b0, 8'h00);
    nxt   = 8'h01;
    guard = 0;
    while (nxt <= 8'h06 && guard < 200) begin
      acc = m_ready;
      cycle("bp_push", 1'b0, 1'b1, nxt);
      if (acc) nxt = nxt + 8'h01;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_errors++;
      $display("FAIL bp_timeout got %0d accepted want 6", nxt - 8'h01);
    end
    repeat (64) cycle("bp_drain", 1'b0, 1'b0, 8'h00);

    // Push exactly on the boundary at edge 41 with an empty FIFO.
    cycle("bnd_rst", 1'b1, 1'b0, 8'h00);
    repeat (40) cycle("bnd_idle", 1'b0, 1'b0, 8'h00);
    cycle("bnd_push", 1'b0, 1'b1, 8'h3C);
    repeat (16) cycle("bnd_out", 1'b0, 1'b0, 8'h00);

    // Reset mid-byte at edge 45 while 8'hA5 is being sent.
    cycle("mid_rst", 1'b1, 1'b0, 8'h00);
    repeat (33) cycle("mid_run", 1'b0, 1'b0, 8'h00);
    cycle("mid_push", 1'b0, 1'b1, 8'hA5);
    repeat (10) cycle("mid_run", 1'b0, 1'b0, 8'h00);
    cycle("mid_abort", 1'b1, 1'b0, 8'h00);
    repeat (48) cycle("mid_restart", 1'b0, 1'b0, 8'h00);

    // Random traffic with rare resets.
    cycle("rand_rst", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 900; i++) begin
      rd = 8'($urandom);
      cycle("rand", ($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
